// File: rtl/i2s_clk_sched.sv
// i2s_clk_sched
//   I2S clock/framing controller. It divides clk_in down to the bit clock,
//   derives the word-select clock, and produces per-bit and per-frame strobes
//   for the serializer. A new divider limit is accepted over a valid/ready
//   handshake and is only applied on a frame boundary. This prevents a rate
//   change from producing a runt bit or a split frame. Start/stop is sequenced
//   so that a stop always completes a whole frame.
//
// Ports
//   clk_in        system clock
//   ar            synchronous active-high reset
//   en            run request (level)
//   cfg_valid     new divider limit offered
//   cfg_limit     offered limit (bclk half-period = limit+1 clk_in cycles)
//   cfg_ready     controller can accept a limit
//   bclk          bit clock
//   lrclk         word select, 0 = left, 1 = right
//   bclk_fall     one-cycle strobe coincident with bclk falling
//   frame_start   one-cycle strobe at the start of each left slot
//   busy          high while running or finishing a stop
//   active_limit  limit currently used by the divider
module i2s_clk_sched #(
  parameter int CNT_W     = 5,
  parameter int DEF_LIMIT = 21,
  parameter int SLOT_BITS = 32
) (
  input  logic             clk_in,
  input  logic             ar,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_limit,
  output logic             cfg_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             bclk_fall,
  output logic             frame_start,
  output logic             busy,
  output logic [CNT_W-1:0] active_limit
);

  localparam int               BW       = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] DEF_L    = CNT_W'(DEF_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pval_q, pval_d;

  logic running, hit, fall, boundary, xfer;

  assign running  = (state_q != S_IDLE);
  assign hit      = (cnt_q >= lim_q);
  // The falling edge of bclk happens on the divider terminal count while bclk is high.
  assign fall     = running && hit && bclk_q;
  // The frame ends when the right slot wraps. lrclk is still 1 in that cycle.
  assign boundary = fall && (bit_q == LAST_BIT) && lrclk_q;
  assign xfer     = cfg_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    fall_d  = 1'b0;
    fs_d    = 1'b0;
    lim_d   = lim_q;
    pend_d  = pend_q;
    pval_d  = pval_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        // While idle, a limit is applied directly. If en rises in the same
        // cycle, the first frame already uses the new limit.
        if (xfer) lim_d = cfg_limit;
        if (en) begin
          state_d = S_RUN;
          fs_d    = 1'b1;
        end
      end
      default: begin
        if (hit) begin
          cnt_d  = '0;
          bclk_d = ~bclk_q;
        end else begin
          cnt_d  = cnt_q + 1'b1;
        end
        if (fall) begin
          fall_d = 1'b1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            lrclk_d = ~lrclk_q;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end
        if (xfer) begin
          pend_d = 1'b1;
          pval_d = cfg_limit;
        end
        if (boundary) begin
          fs_d = 1'b1;
          if (pend_q) begin
            lim_d  = pval_q;
            pend_d = 1'b0;
          end
        end
        // A stop finishes on the frame boundary. At that point the divider has
        // already returned bclk, lrclk and the counters to 0, so IDLE starts clean.
        if (state_q == S_RUN) begin
          if (!en) state_d = S_STOP;
        end else begin
          if (en)            state_d = S_RUN;
          else if (boundary) state_d = S_IDLE;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
    // ready stays low through the frame_start cycle of the applied limit and
    // rises one cycle later.
    rdy_d  = !pend_d && !(boundary && pend_q);
  end

  always_ff @(posedge clk_in) begin
    if (ar) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      fall_q  <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      lim_q   <= DEF_L;
      pend_q  <= 1'b0;
      pval_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      fall_q  <= fall_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      lim_q   <= lim_d;
      pend_q  <= pend_d;
      pval_q  <= pval_d;
    end
  end

  assign cfg_ready    = rdy_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign bclk_fall    = fall_q;
  assign frame_start  = fs_q;
  assign busy         = busy_q;
  assign active_limit = lim_q;

endmodule
